// File: rtl/glb_read_pkg.sv
// Shared types and width helpers for the GLB read sink and its helpers.
package glb_read_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_e;

    // Count must be able to hold DEPTH itself, hence the +1.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/glb_stall_gen.sv
// Modulo counter that flags one stall slot every PERIOD enabled cycles.
module glb_stall_gen #(
    parameter int PERIOD = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic stall_o
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((PERIOD > 0) ? PERIOD - 1 : 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_o = (PERIOD != 0) && (cnt_q == LAST);

endmodule

// File: rtl/glb_read.sv
// Stream sink: captures TX_SIZE words after start into a local buffer with registered readback.
module glb_read
    import glb_read_pkg::*;
#(
    parameter int TX_SIZE      = 32,
    parameter int DEPTH        = 1024,
    parameter int STALL_PERIOD = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic                        clear_i,
    input  logic [DATA_W-1:0]           data_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic                        done_o,
    output logic [count_w(DEPTH)-1:0]   count_o,
    input  logic [addr_w(DEPTH)-1:0]    rd_addr_i,
    output logic [DATA_W-1:0]           rd_data_o
);

    localparam int CW = count_w(DEPTH);
    localparam int AW = addr_w(DEPTH);
    localparam logic [CW-1:0] TX_LAST = CW'(TX_SIZE);

    if ((TX_SIZE > DEPTH) || (TX_SIZE < 0)) begin : g_bad_tx_size
        $error("glb_read: TX_SIZE must lie in 0..DEPTH");
    end

    state_e            state_q;
    state_e            state_d;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              stall;
    logic              xfer;

    // Counter is held at zero outside RECV so every run starts a fresh stall phase.
    glb_stall_gen #(
        .PERIOD (STALL_PERIOD)
    ) u_stall (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (state_q != RECV),
        .en_i    (state_q == RECV),
        .stall_o (stall)
    );

    assign ready_o = (state_q == RECV) && !stall;
    assign done_o  = (state_q == DONE);
    assign count_o = count_q;
    assign xfer    = valid_i && ready_o;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    count_d = '0;
                    state_d = (TX_SIZE == 0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (xfer) begin
                    count_d = count_q + CW'(1);
                    if (count_q + CW'(1) == TX_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (clear_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Buffer deliberately has no reset so contents survive rst_n between runs.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[count_q[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
